// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Round-robin arbiter sharing one dual-port RAM between two
//            requesters. Clears the RAM after reset, then services one
//            read or write per cycle and routes read data back to the
//            requester that asked for it.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid_0,
    input  logic               req_write_0,
    input  logic [A_WIDTH-1:0] req_address_0,
    input  logic [D_WIDTH-1:0] req_data_0,
    output logic               req_ready_0,
    output logic               rsp_valid_0,
    output logic [D_WIDTH-1:0] rsp_data_0,
    input  logic               req_valid_1,
    input  logic               req_write_1,
    input  logic [A_WIDTH-1:0] req_address_1,
    input  logic [D_WIDTH-1:0] req_data_1,
    output logic               req_ready_1,
    output logic               rsp_valid_1,
    output logic [D_WIDTH-1:0] rsp_data_1,
    output logic               init_done,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_write_enable,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    localparam logic [0:0]         c_st_init = 1'b0;
    localparam logic [0:0]         c_st_run  = 1'b1;
    localparam int                 c_last_i  = A_MAX - 1;
    localparam logic [A_WIDTH-1:0] c_last    = c_last_i[A_WIDTH-1:0];
    localparam logic [A_WIDTH:0]   c_a_max   = A_MAX[A_WIDTH:0];
    localparam logic [A_WIDTH-1:0] c_one     = {{(A_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [A_WIDTH-1:0] r_count;
    logic               r_ptr;        // 0: requester 0 wins a tie, 1: requester 1
    logic               r_init_done;
    logic               r_rsp_pend;
    logic               r_rsp_sel;
    logic               r_rsp_oor;
    logic [D_WIDTH-1:0] r_hold_0;
    logic [D_WIDTH-1:0] r_hold_1;

    logic               w_run;
    logic               w_gnt_0;
    logic               w_gnt_1;
    logic               w_any;
    logic               w_xfer_write;
    logic [A_WIDTH-1:0] w_xfer_addr;
    logic [D_WIDTH-1:0] w_xfer_data;
    logic               w_xfer_oor;
    logic [D_WIDTH-1:0] w_rsp_word;
    logic [D_WIDTH-1:0] w_rsp_data_0;
    logic [D_WIDTH-1:0] w_rsp_data_1;

    // Grant selection: a lone requester always wins, a tie goes to the pointer.
    assign w_run        = (r_state == c_st_run);
    assign w_gnt_0      = w_run && req_valid_0 && (!req_valid_1 || !r_ptr);
    assign w_gnt_1      = w_run && req_valid_1 && (!req_valid_0 ||  r_ptr);
    assign w_any        = w_gnt_0 || w_gnt_1;
    assign w_xfer_write = w_gnt_1 ? req_write_1   : req_write_0;
    assign w_xfer_addr  = w_gnt_1 ? req_address_1 : req_address_0;
    assign w_xfer_data  = w_gnt_1 ? req_data_1    : req_data_0;
    assign w_xfer_oor   = ({1'b0, w_xfer_addr} >= c_a_max);

    // Out-of-range reads return zero; the idle requester keeps its last word.
    assign w_rsp_word   = r_rsp_oor ? '0 : ram_data_read;
    assign w_rsp_data_0 = (r_rsp_pend && !r_rsp_sel) ? w_rsp_word : r_hold_0;
    assign w_rsp_data_1 = (r_rsp_pend &&  r_rsp_sel) ? w_rsp_word : r_hold_1;

    // State register: restart the clear sweep on every reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave the sweep once the last location has been written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_init: if (r_count == c_last) w_state_next = c_st_run;
            default:   w_state_next = c_st_run;
        endcase
    end

    // Sweep counter, priority pointer, pending response and held read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_ptr       <= 1'b0;
            r_init_done <= 1'b0;
            r_rsp_pend  <= 1'b0;
            r_rsp_sel   <= 1'b0;
            r_rsp_oor   <= 1'b0;
            r_hold_0    <= '0;
            r_hold_1    <= '0;
        end else begin
            if (r_state == c_st_init) begin
                r_count <= r_count + c_one;
            end
            r_init_done <= (w_state_next == c_st_run);
            if (w_any) begin
                r_ptr <= w_gnt_0;
            end
            r_rsp_pend <= w_any && !w_xfer_write;
            r_rsp_sel  <= w_gnt_1;
            r_rsp_oor  <= w_xfer_oor;
            r_hold_0   <= w_rsp_data_0;
            r_hold_1   <= w_rsp_data_1;
        end
    end

    // Outputs: everything held low while reset is asserted.
    always_comb begin
        req_ready_0       = 1'b0;
        req_ready_1       = 1'b0;
        rsp_valid_0       = 1'b0;
        rsp_valid_1       = 1'b0;
        rsp_data_0        = '0;
        rsp_data_1        = '0;
        init_done         = 1'b0;
        ram_write_enable  = 1'b0;
        ram_address_write = '0;
        ram_data_write    = '0;
        ram_address_read  = '0;
        if (reset_n) begin
            init_done   = r_init_done;
            req_ready_0 = w_gnt_0;
            req_ready_1 = w_gnt_1;
            rsp_valid_0 = r_rsp_pend && !r_rsp_sel;
            rsp_valid_1 = r_rsp_pend &&  r_rsp_sel;
            rsp_data_0  = w_rsp_data_0;
            rsp_data_1  = w_rsp_data_1;
            case (r_state)
                c_st_init: begin
                    ram_write_enable  = 1'b1;
                    ram_address_write = r_count;
                end
                default: begin
                    if (w_any) begin
                        if (w_xfer_write) begin
                            if (!w_xfer_oor) begin
                                ram_write_enable  = 1'b1;
                                ram_address_write = w_xfer_addr;
                                ram_data_write    = w_xfer_data;
                            end
                        end else begin
                            ram_address_read = w_xfer_addr;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Controller that shares one dual-port RAM (separate write and read ports, both clocked from `clk` at integration) between two requesters using round-robin arbitration.
- After reset it sweeps the RAM clear, writing zero to every location, before granting any request.
- Returns read data to the originating requester with a valid strobe. Sits between client logic and the `ram` instance.

Parameters:
D_WIDTH, 8, data word width
A_WIDTH, 5, address width
A_MAX, 32, number of implemented locations (<= 2^A_WIDTH)

Ports:
clk  input  1  single clock; also drives RAM clk_write and clk_read
reset_n  input  1  synchronous, active-low reset
req_valid_0  input  1  requester 0 has a request
req_write_0  input  1  requester 0: 1 = write, 0 = read
req_address_0  input  A_WIDTH  requester 0 address
req_data_0  input  D_WIDTH  requester 0 write data
req_ready_0  output  1  requester 0 granted this cycle
rsp_valid_0  output  1  requester 0 read data valid
rsp_data_0  output  D_WIDTH  requester 0 read data
req_valid_1, req_write_1, req_address_1, req_data_1, req_ready_1, rsp_valid_1, rsp_data_1: same as requester 0
init_done  output  1  clear sweep complete
ram_address_write  output  A_WIDTH  to RAM address_write
ram_data_write  output  D_WIDTH  to RAM data_write
ram_write_enable  output  1  to RAM write_enable
ram_address_read  output  A_WIDTH  to RAM address_read
ram_data_read  input  D_WIDTH  from RAM data_read (valid one clk after address is presented)

Behaviour:
- Reset: `reset_n` is sampled only at `clk` rising edge. While `reset_n` = 0, all outputs are forced to 0 combinationally: ready, rsp_valid, rsp_data, init_done, ram_write_enable, and all ram_* buses. On the reset edge: state = INIT, sweep counter = 0, priority pointer = requester 0, pending-response register cleared.
- FSM INIT:
  - Each cycle drive ram_write_enable = 1, ram_address_write = counter, ram_data_write = 0; then counter++.
  - After writing A_MAX-1, go to RUN. INIT lasts exactly A_MAX cycles.
  - req_ready_0 = req_ready_1 = 0 throughout; init_done = 0.
- FSM RUN: init_done = 1 (registered), stays 1 until the next reset.
- Arbitration (RUN only):
  - At most one grant per cycle. If one requester is valid, grant it.
  - If both are valid, grant the requester indicated by the priority pointer; the pointer then moves to the other requester.
  - The pointer updates only on a granted transfer.
  - req_ready_i is combinational: (state == RUN) && grant_i.
  - A transfer occurs when req_valid_i && req_ready_i. Requesters hold request fields stable while valid && !ready.
- Write transfer: same cycle, ram_write_enable = 1, ram_address_write = req_address_i, ram_data_write = req_data_i. No response is generated.
- Read transfer: same cycle, ram_address_read = req_address_i. Next cycle, rsp_valid_i = 1 for exactly one cycle with rsp_data_i = ram_data_read. Read latency is 1 cycle from the handshake.
- ram_write_enable = 0 whenever there is no write transfer and state != INIT.
- rsp_data_i of the requester not responding is held at its last value. Only rsp_valid_i qualifies it.
- Read-after-write: a write to address X at cycle N followed by a read of X at cycle N+1 or later returns the new data. The same cycle is impossible because there is one grant per cycle.
- Back-to-back reads: sustained one per cycle. Responses stay in order and are correctly routed per requester.
- Out-of-range address (>= A_MAX, possible only when A_MAX < 2^A_WIDTH):
  - Write is accepted (ready = 1) but ram_write_enable stays 0.
  - Read is accepted and returns rsp_data = 0 with rsp_valid.
- Reset mid-operation: any pending response is dropped (no rsp_valid after reset). The sweep restarts from address 0. A partial earlier sweep has no effect on the result.
- ram_address_read and ram_address_write idle at 0 when unused.

Test Plan:
- Reset then idle, A_MAX = 32 → ram_write_enable high for exactly 32 cycles with addresses 0..31 and data 0x00; init_done rises the cycle after address 31; no ready during the sweep.
- After init, requester 0 writes 0x1B/0xC5 then reads 0x1B → ready on both handshakes; rsp_valid_0 one cycle after the read handshake with rsp_data_0 = 0xC5; rsp_valid_1 stays 0.
- Both requesters hold valid reads (req 0 at addr 0x03, req 1 at 0x04, preloaded 0x11/0x22) for 4 cycles → grants alternate 0,1,0,1; responses alternate 0x11 to requester 0 and 0x22 to requester 1, each one cycle after its grant.
- Requester 1 writes 0x05 = 0xA7 at cycle N; requester 0 reads 0x05 at N+1 → rsp_data_0 = 0xA7 at N+2.
- Read handshake, then reset_n = 0 on the next edge → no rsp_valid; INIT restarts at address 0; a previously written location reads 0x00 after the new sweep.
- A_MAX = 24: write 0xFF to address 25, then read 25 → no RAM write enable; rsp_data = 0x00 with rsp_valid.
